// File: rtl/sha256_blk_seq_pkg.sv
// Shared types and constants for the SHA-256 message-block sequencer.
package sha256_blk_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PAD,
    ISSUE,
    WAIT,
    XPAD
  } state_t;

  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned LEN_FIT_MAX = 55;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;
  localparam int unsigned IDX_W       = $clog2(BLOCK_WORDS);
  // Byte position 0..64 within a block
  localparam int unsigned POS_W       = 7;

endpackage

// File: rtl/sha256_blk_buf.sv
// 16x32 message block register: word write with byte masking, pad-byte
// insertion, extra-block construction and 64-bit length insertion.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   wr_en/wr_idx/wr_data  store a stream word at word index wr_idx
//   wr_bytes              valid bytes of the word (1..4); later bytes -> 0
//   pad_en/pad_pos        0x80 at byte pad_pos, zero every later byte
//   len_en                with pad_en, place len in words 14..15
//   xpad_en/xpad_mark     clear block, optional 0x80 in byte 0, place len
//   len                   message bit length
//   block                 block contents, word 0 in [511:480]
module sha256_blk_buf
  import sha256_blk_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [2:0]       wr_bytes,
  input  logic             pad_en,
  input  logic [POS_W-1:0] pad_pos,
  input  logic             len_en,
  input  logic             xpad_en,
  input  logic             xpad_mark,
  input  logic [63:0]      len,
  output logic [511:0]     block
);

  logic [511:0] blk_nxt;

  // Byte-wise next value; byte b lives in block[511-8*b -: 8]
  always_comb begin
    blk_nxt = block;
    for (int b = 0; b < 64; b++) begin
      if (wr_en && (IDX_W'(b >> 2) == wr_idx)) begin
        blk_nxt[511-8*b -: 8] = ({1'b0, 2'(b)} < wr_bytes) ? wr_data[31-8*(b%4) -: 8] : 8'h00;
      end
      if (pad_en) begin
        if (POS_W'(b) == pad_pos) begin
          blk_nxt[511-8*b -: 8] = PAD_BYTE;
        end else if (POS_W'(b) > pad_pos) begin
          blk_nxt[511-8*b -: 8] = 8'h00;
        end
      end
      if (xpad_en) begin
        blk_nxt[511-8*b -: 8] = ((b == 0) && xpad_mark) ? PAD_BYTE : 8'h00;
      end
    end
    // Length goes last so it overrides the zero fill of words 14..15
    if ((pad_en && len_en) || xpad_en) begin
      blk_nxt[63:0] = len;
    end
  end

  // Block storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block <= '0;
    end else begin
      block <= blk_nxt;
    end
  end

endmodule

// File: rtl/sha256_blk_seq.sv
// SHA-256 message-block sequencer: assembles a byte-granular word stream
// into 512-bit blocks, applies padding and length, and drives init/next
// pulses into the compression core.
// Ports:
//   ACLK, ARESETN           clock, async active-low reset
//   msg_valid/ready/data    word stream, big-endian, first byte in [31:24]
//   msg_last, msg_bytes     final word flag and its valid byte count (0 = 4)
//   core_init, core_next    one-cycle block start pulses to the core
//   core_block              block presented to the core
//   core_ready              core idle
//   busy                    message in progress
//   done                    one-cycle pulse, final digest valid
//   abort                   only with SHA256_BLK_SEQ_ABORT_EN: cancel message
module sha256_blk_seq
  import sha256_blk_seq_pkg::*;
#(
  parameter int unsigned LEN_W     = 64,
  parameter int unsigned READY_DLY = 1
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_data,
  input  logic         msg_last,
  input  logic [1:0]   msg_bytes,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] core_block,
  input  logic         core_ready,
  output logic         busy,
  output logic         done
`ifdef SHA256_BLK_SEQ_ABORT_EN
  ,
  input  logic         abort
`endif
);

  localparam int unsigned DLY_W = (READY_DLY < 2) ? 1 : $clog2(READY_DLY + 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [LEN_W-1:0] len;
  logic [POS_W-1:0] pos;
  logic [DLY_W-1:0] dly;
  logic             ready_q;
  logic             first;
  logic             xblk;
  logic             fin;
  logic             abort_pend;
  logic             abort_c;
  logic             xfer_c;
  logic [2:0]       nbytes_c;
  logic [POS_W-1:0] pos_c;

`ifdef SHA256_BLK_SEQ_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // The word offered in an abort cycle is refused
  assign msg_ready = ready_q & ~abort_c;
  assign xfer_c    = msg_valid & msg_ready;
  assign nbytes_c  = (msg_last && (msg_bytes != 2'd0)) ? {1'b0, msg_bytes} : 3'd4;
  assign pos_c     = POS_W'({idx, 2'b00}) + POS_W'(nbytes_c);

  sha256_blk_buf u_buf (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .wr_en     (xfer_c),
    .wr_idx    (idx),
    .wr_data   (msg_data),
    .wr_bytes  (nbytes_c),
    .pad_en    ((state == PAD) && !abort_c),
    .pad_pos   (pos),
    .len_en    (pos <= POS_W'(LEN_FIT_MAX)),
    .xpad_en   (state == XPAD),
    .xpad_mark (pos == POS_W'(64)),
    .len       (64'(len)),
    .block     (core_block)
  );

  // Sequencing FSM with registered outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      core_init  <= 1'b0;
      core_next  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      idx        <= '0;
      len        <= '0;
      pos        <= '0;
      dly        <= '0;
      first      <= 1'b1;
      xblk       <= 1'b0;
      fin        <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      core_init <= 1'b0;
      core_next <= 1'b0;
      done      <= 1'b0;
      if (abort_c && ((state == FILL) || (state == PAD) || (state == ISSUE))) begin
        state      <= IDLE;
        ready_q    <= 1'b0;
        busy       <= 1'b0;
        idx        <= '0;
        len        <= '0;
        first      <= 1'b1;
        xblk       <= 1'b0;
        fin        <= 1'b0;
        abort_pend <= 1'b0;
      end else begin
        case (state)
          IDLE, FILL: begin
            if (state == IDLE) begin
              ready_q <= 1'b1;
            end
            if (xfer_c) begin
              busy <= 1'b1;
              idx  <= idx + IDX_W'(1);
              len  <= len + LEN_W'({nbytes_c, 3'b000});
              if (msg_last) begin
                pos     <= pos_c;
                ready_q <= 1'b0;
                state   <= PAD;
              end else if (idx == IDX_W'(BLOCK_WORDS - 1)) begin
                ready_q <= 1'b0;
                state   <= ISSUE;
              end else begin
                state <= FILL;
              end
            end
          end
          PAD: begin
            // Length only fits when at least 8 bytes remain after the pad byte
            fin   <= (pos <= POS_W'(LEN_FIT_MAX));
            xblk  <= (pos > POS_W'(LEN_FIT_MAX));
            state <= ISSUE;
          end
          ISSUE: begin
            if (core_ready) begin
              core_init <= first;
              core_next <= ~first;
              first     <= 1'b0;
              dly       <= DLY_W'(READY_DLY);
              state     <= WAIT;
            end
          end
          WAIT: begin
            if (abort_c) begin
              abort_pend <= 1'b1;
            end
            // core_ready may still be stale right after the pulse
            if (dly != '0) begin
              dly <= dly - DLY_W'(1);
            end else if (core_ready) begin
              if (fin || abort_pend || abort_c) begin
                done       <= fin & ~abort_pend & ~abort_c;
                state      <= IDLE;
                ready_q    <= 1'b0;
                busy       <= 1'b0;
                idx        <= '0;
                len        <= '0;
                first      <= 1'b1;
                xblk       <= 1'b0;
                fin        <= 1'b0;
                abort_pend <= 1'b0;
              end else if (xblk) begin
                state <= XPAD;
              end else begin
                idx     <= '0;
                ready_q <= 1'b1;
                state   <= FILL;
              end
            end
          end
          XPAD: begin
            fin   <= 1'b1;
            xblk  <= 1'b0;
            state <= ISSUE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha256_blk_seq.sv
// Scoreboard bench for sha256_blk_seq: directed messages push expected
// core blocks and done pulses; a monitor pops and compares on each pulse.
// The abort scenario is included when SHA256_BLK_SEQ_ABORT_EN is defined.
`timescale 1ns/1ps
module tb_sha256_blk_seq;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic         msg_valid = 1'b0;
  logic         msg_ready;
  logic [31:0]  msg_data = '0;
  logic         msg_last = 1'b0;
  logic [1:0]   msg_bytes = '0;
  logic         core_init;
  logic         core_next;
  logic [511:0] core_block;
  logic         core_ready;
  logic         busy;
  logic         done;
`ifdef SHA256_BLK_SEQ_ABORT_EN
  logic         abort = 1'b0;
`endif

  // Simple core: busy for a few cycles after each start pulse
  logic hold_ready = 1'b0;
  int   core_cnt = 0;
  assign core_ready = !hold_ready && (core_cnt == 0);

  int errors = 0;
  int checks = 0;

  typedef struct {
    int           kind;  // 0 init, 1 next, 2 done
    logic [511:0] blk;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] msg_w [32];

  sha256_blk_seq dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_data   (msg_data),
    .msg_last   (msg_last),
    .msg_bytes  (msg_bytes),
    .core_init  (core_init),
    .core_next  (core_next),
    .core_block (core_block),
    .core_ready (core_ready),
    .busy       (busy),
    .done       (done)
`ifdef SHA256_BLK_SEQ_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Core model
  initial forever begin
    @(negedge ACLK);
    if (!ARESETN) core_cnt = 0;
    else if (core_init || core_next) core_cnt = 6;
    else if (core_cnt > 0) core_cnt = core_cnt - 1;
  end

  // Monitor: pop and compare on every start pulse and done pulse
  initial forever begin
    exp_t e;
    @(negedge ACLK);
    if (ARESETN && (core_init || core_next || done)) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got init=%0b next=%0b done=%0b with nothing expected",
                 core_init, core_next, done);
      end else begin
        e = sbq.pop_front();
        if (e.kind == 2) begin
          if (!done || core_init || core_next) begin
            errors++;
            $display("FAIL sb_done: got init=%0b next=%0b done=%0b want done pulse",
                     core_init, core_next, done);
          end
        end else if (core_init !== (e.kind == 0) || core_next !== (e.kind == 1) || done
                     || core_block !== e.blk) begin
          errors++;
          $display("FAIL sb_block: got init=%0b next=%0b done=%0b block=%h want kind=%0d block=%h",
                   core_init, core_next, done, core_block, e.kind, e.blk);
        end
      end
    end
  end

  function automatic logic [31:0] wd(input int i);
    return {8'(i + 1), 8'hB1, 8'hC2, 8'hD3};
  endfunction

  function automatic logic [511:0] data_blk(input int n);
    logic [511:0] b = '0;
    for (int i = 0; i < n; i++) b[511-32*i -: 32] = wd(i);
    return b;
  endfunction

  task automatic push(input int kind, input logic [511:0] blk);
    exp_t e;
    e.kind = kind;
    e.blk  = blk;
    sbq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic send_msg(input int n, input logic [1:0] lb, input bit end_msg);
    bit ok;
    bit r;
    for (int i = 0; i < n; i++) begin
      msg_data  = msg_w[i];
      msg_last  = end_msg && (i == n - 1);
      msg_bytes = msg_last ? lb : 2'd0;
      msg_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge ACLK);
        r = msg_ready;
        @(posedge ACLK);
        #1;
        ok = r;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: word %0d not accepted within 200 cycles", i);
      end
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    msg_bytes = 2'd0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge ACLK);
      ok = (sbq.size() == 0) && !busy;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d expected events left, busy=%0b", name, sbq.size(), busy);
    end
    repeat (2) @(posedge ACLK);
    #1;
  endtask

  task automatic run_abc(input string name);
    logic [511:0] e = '0;
    msg_w[0] = 32'h61626300;
    e[511:480] = 32'h61626380;
    e[63:0]    = 64'd24;
    push(0, e);
    push(2, '0);
    send_msg(1, 2'd3, 1'b1);
    wait_idle(name);
  endtask

  initial begin
    logic [511:0] e;
    logic [511:0] e2;
    logic [31:0]  tmp;
    int           bad;
    bit           seen;

    // Reset values
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_msg_ready", msg_ready, 0);
    chk("rst_core_init", core_init, 0);
    chk("rst_core_next", core_next, 0);
    chk("rst_core_block", core_block, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    ARESETN = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("idle_msg_ready", msg_ready, 1);
    @(posedge ACLK);
    #1;

    // "abc": single block via init
    run_abc("abc");

    // 22 bytes: last word keeps 2 bytes, garbage bytes masked
    for (int i = 0; i < 6; i++) msg_w[i] = wd(i);
    e = data_blk(5);
    tmp = wd(5);
    e[351:320] = {tmp[31:16], 16'h8000};
    e[63:0] = 64'd176;
    push(0, e);
    push(2, '0);
    send_msg(6, 2'd2, 1'b1);
    wait_idle("b22");

    // 55 bytes: largest message whose length still fits
    for (int i = 0; i < 14; i++) msg_w[i] = wd(i);
    e = data_blk(13);
    tmp = wd(13);
    e[511-32*13 -: 32] = {tmp[31:8], 8'h80};
    e[63:0] = 64'd440;
    push(0, e);
    push(2, '0);
    send_msg(14, 2'd3, 1'b1);
    wait_idle("b55");

    // 56 bytes: pad byte in word 14, length in extra block
    e = data_blk(14);
    e[511-32*14 -: 32] = 32'h80000000;
    e2 = '0;
    e2[63:0] = 64'd448;
    push(0, e);
    push(1, e2);
    push(2, '0);
    send_msg(14, 2'd0, 1'b1);
    wait_idle("b56");

    // 64 bytes: pure data block, pad byte starts extra block
    for (int i = 0; i < 16; i++) msg_w[i] = wd(i);
    e = data_blk(16);
    e2 = '0;
    e2[511:480] = 32'h80000000;
    e2[63:0] = 64'd512;
    push(0, e);
    push(1, e2);
    push(2, '0);
    send_msg(16, 2'd0, 1'b1);
    wait_idle("b64");

    // 80 bytes: second block refilled, stale words must be cleared
    for (int i = 0; i < 20; i++) msg_w[i] = wd(i);
    e = data_blk(16);
    e2 = '0;
    for (int i = 16; i < 20; i++) e2[511-32*(i-16) -: 32] = wd(i);
    e2[383:352] = 32'h80000000;
    e2[63:0] = 64'd640;
    push(0, e);
    push(1, e2);
    push(2, '0);
    send_msg(20, 2'd0, 1'b1);
    wait_idle("b80");

    // Backpressure: core_ready held low while the block waits in ISSUE
    hold_ready = 1'b1;
    msg_w[0] = 32'h61626300;
    e = '0;
    e[511:480] = 32'h61626380;
    e[63:0] = 64'd24;
    push(0, e);
    push(2, '0);
    send_msg(1, 2'd3, 1'b1);
    bad = 0;
    for (int c = 0; c < 22; c++) begin
      @(negedge ACLK);
      if (core_init || core_next || msg_ready) bad++;
    end
    chk("bp_quiet_cycles", 32'(bad), 0);
    @(posedge ACLK);
    #1;
    hold_ready = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("bp_first_ready_pulse", core_init, 1);
    wait_idle("bp");

    // Reset in WAIT of the first block of a two-block message
    for (int i = 0; i < 14; i++) msg_w[i] = wd(i);
    e = data_blk(14);
    e[511-32*14 -: 32] = 32'h80000000;
    push(0, e);
    push(1, '0);
    push(2, '0);
    send_msg(14, 2'd0, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge ACLK);
      seen = core_init;
    end
    chk("rw_init_seen", seen, 1);
    @(posedge ACLK);
    #1;
    ARESETN = 1'b0;
    #1;
    chk("rw_msg_ready", msg_ready, 0);
    chk("rw_core_init", core_init, 0);
    chk("rw_core_next", core_next, 0);
    chk("rw_core_block", core_block, 0);
    chk("rw_busy", busy, 0);
    chk("rw_done", done, 0);
    sbq.delete();
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    run_abc("post_reset_abc");

`ifdef SHA256_BLK_SEQ_ABORT_EN
    // Abort during FILL with five words already stored
    for (int i = 0; i < 6; i++) msg_w[i] = wd(i);
    send_msg(5, 2'd0, 1'b0);
    msg_data  = msg_w[5];
    msg_valid = 1'b1;
    abort     = 1'b1;
    @(negedge ACLK);
    chk("ab_ready_forced", msg_ready, 0);
    @(posedge ACLK);
    #1;
    abort     = 1'b0;
    msg_valid = 1'b0;
    @(negedge ACLK);
    chk("ab_busy_clear", busy, 0);
    repeat (10) @(posedge ACLK);
    #1;
    run_abc("post_abort_abc");
`endif

    chk("sb_empty", 32'(sbq.size()), 0);
    repeat (3) @(posedge ACLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_blk_seq.md
Name: sha256_blk_seq

Overview:
- Message-block sequencer in front of the SHA-256 compression core inside the sha256 peripheral.
- Accepts a byte-granular 32-bit word stream and assembles 512-bit blocks in a single buffer.
- Applies FIPS 180-4 padding and the 64-bit length field.
- Pulses core init on the first block and core next on each later block; signals completion when the final digest is valid.

Parameters:
- LEN_W, 64, width of the message bit-length counter. The length field is zero-extended to 64 bits; values other than 64 are for synthesis trimming only.
- READY_DLY, 1, cycles after an init/next pulse during which core_ready is ignored.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- msg_valid  in  1  stream word valid.
- msg_ready  out  1  stream word accepted when msg_valid & msg_ready.
- msg_data  in  32  message word, big-endian; first byte in [31:24].
- msg_last  in  1  final word of the message.
- msg_bytes  in  2  valid bytes in the last word; 0 means 4. Ignored when msg_last=0.
- core_init  out  1  one-cycle pulse: first block of a message.
- core_next  out  1  one-cycle pulse: subsequent block.
- core_block  out  512  block to the core; word 0 in [511:480].
- core_ready  in  1  core idle.
- busy  out  1  message in progress.
- done  out  1  one-cycle pulse: final digest valid at the core.

Behaviour:
- Reset values: msg_ready=0, core_init=0, core_next=0, core_block=0, busy=0, done=0, state=IDLE, word index=0, length=0, first flag=1.
- IDLE: msg_ready=1.
  - First accepted word: store it in word 0, set busy=1, go to FILL.
- FILL: msg_ready=1; each transfer writes buffer[idx] and increments idx.
  - Full word adds 32 to length. Last word adds 8*msg_bytes.
  - Bytes of the last word beyond msg_bytes are forced to 0.
  - Transfer with idx=15 and msg_last=0 goes to ISSUE.
  - Transfer with msg_last goes to PAD.
- PAD (one cycle):
  - Pad byte position p = 4*idx_last + bytes, range 1..64.
  - If p<64: byte p=0x80 and bytes p+1..63 are zeroed.
  - If p<=55: words 14..15 = length; mark the block final.
  - Otherwise: set the extra-block flag, which is pending until the current block is issued.
  - Then go to ISSUE.
- ISSUE: msg_ready=0.
  - When core_ready=1: pulse core_init if the first flag is set, else core_next. Clear the first flag. Go to WAIT.
- WAIT: core_block held stable.
  - Ignore core_ready for READY_DLY cycles after the pulse, then wait for core_ready=1.
  - If the block was final: done=1 for one cycle, busy=0, go to IDLE.
  - Else if the extra-block flag is set: go to XPAD.
  - Else: idx=0, go to FILL.
- XPAD (one cycle):
  - Buffer = zeros; word 0 = 0x80000000 only if p=64; words 14..15 = length; mark final; go to ISSUE.
- Clean-up on return to IDLE: length, first flag and extra-block flag are reset. msg_ready returns to 1 the cycle after done.
- Single buffer: msg_ready=0 in PAD, ISSUE, WAIT and XPAD.
- Length counter wraps modulo 2^LEN_W; messages of 2^64 bits or more are unsupported.
- Empty messages are unsupported: msg_last on the first word with msg_bytes=0 means 4 bytes.
- ARESETN low in any state returns all outputs to reset values immediately. No done pulse. The core is reset on its own path.

Optional Feature:
- Macro SHA256_BLK_SEQ_ABORT_EN adds input abort (1 bit, synchronous).
- With the macro, abort=1 behaves per state:
  - FILL or PAD: discard the buffer, go to IDLE.
  - ISSUE: no pulse is issued, go to IDLE.
  - WAIT: finish the wait for core_ready, then go to IDLE with no done pulse.
  - In all cases the word presented in the abort cycle is not accepted (msg_ready forced 0) and busy clears on entering IDLE.
- Without the macro the port is absent and sequencing is uninterruptible except by reset.

Decomposition:
- Package sha256_blk_seq_pkg:
  - state enum IDLE/FILL/PAD/ISSUE/WAIT/XPAD;
  - BLOCK_WORDS=16, LEN_FIT_MAX=55, PAD_BYTE=8'h80.
- Sub-module sha256_blk_buf: 16x32 block register with word write, byte masking, pad-byte insertion and length insertion. The FSM and counters stay in sha256_blk_seq.

Test Plan:
- "abc": one word 0x61626300, msg_bytes=3, last.
  - core_block = 0x61626380, zeros, 0x00000000_00000018; one core_init, no core_next.
  - done after core_ready returns; reference core digest ba7816bf...f20015ad.
- 56-byte message, 14 words, last bytes=4.
  - Block 0: data + 0x80000000 in word 14 + zeros, via core_init.
  - Block 1: zeros + length 0x1C0, via core_next; done once.
- 64-byte message, 16 words.
  - Block 0 is pure data via init.
  - Block 1: word 0=0x80000000, length 0x200, via next.
- Backpressure: hold core_ready=0 for 20 cycles in ISSUE.
  - No init/next pulse; msg_ready=0 throughout; pulse on the first cycle core_ready=1.
- ARESETN asserted mid-WAIT of the first block of a 2-block message.
  - All outputs 0 in the same cycle; after release the next message starts with core_init and length counted from 0.
- With SHA256_BLK_SEQ_ABORT_EN: abort during FILL at idx=5.
  - busy=0 next cycle, no pulse, no done; the next "abc" message yields the correct single-block result.
